// File: rtl/mem_port_arbiter_if.sv
// Memory/MIO bus bundle between the port arbiter (master) and the memory system (slave).
interface mem_port_arbiter_if;
    logic        bus_req;
    logic        bus_we;
    logic [31:0] bus_addr;
    logic [31:0] bus_wdata;
    logic [2:0]  bus_type;
    logic [31:0] bus_rdata;
    logic        bus_ready;

    modport master (
        output bus_req, bus_we, bus_addr, bus_wdata, bus_type,
        input  bus_rdata, bus_ready
    );

    modport slave (
        input  bus_req, bus_we, bus_addr, bus_wdata, bus_type,
        output bus_rdata, bus_ready
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// Shares one memory/MIO port between the IF fetch and MEM data requesters.
// Optional bus-ready timeout with sticky bus_err is enabled by defining ARB_TIMEOUT_EN.
module mem_port_arbiter #(
    parameter int TIMEOUT = 255,
    parameter int TO_W    = 8
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      if_req,
    input  logic [31:0]               if_addr,
    input  logic                      if_flush,
    output logic                      if_done,
    output logic                      if_valid,
    output logic [31:0]               if_inst,
    input  logic                      dm_req,
    input  logic                      dm_we,
    input  logic [31:0]               dm_addr,
    input  logic [31:0]               dm_wdata,
    input  logic [2:0]                dm_type,
    output logic                      dm_done,
    output logic [31:0]               dm_rdata,
    output logic                      stall,
    output logic                      bus_err,
    mem_port_arbiter_if.master        bus
);

    typedef enum logic [1:0] {IDLE, D_ACC, I_ACC} state_t;

    localparam logic [31:0] NOP_INST = 32'h0000_0013;

    if (TIMEOUT >= (1 << TO_W)) begin : g_timeout_range
        $error("mem_port_arbiter: TIMEOUT must be below 2**TO_W");
    end

    state_t      state_reg, state_next;
    logic        last_data_reg, last_data_next;
    logic [31:0] addr_reg, addr_next;
    logic [31:0] wdata_reg, wdata_next;
    logic        we_reg, we_next;
    logic [2:0]  type_reg, type_next;
    logic        drop_reg, drop_next;
    logic        if_done_reg, if_done_next;
    logic        if_valid_reg, if_valid_next;
    logic        dm_done_reg, dm_done_next;
    logic [31:0] if_inst_reg, if_inst_next;
    logic [31:0] dm_rdata_reg, dm_rdata_next;

    logic        if_elig;
    logic        dm_elig;
    logic        flushed;

`ifdef ARB_TIMEOUT_EN
    logic [TO_W-1:0] to_cnt_reg, to_cnt_next;
    logic            bus_err_reg, bus_err_next;
`endif

    assign if_elig = if_req & ~if_done_reg;
    assign dm_elig = dm_req & ~dm_done_reg;
    assign flushed = drop_reg | if_flush;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg     <= IDLE;
            last_data_reg <= 1'b0;
            addr_reg      <= '0;
            wdata_reg     <= '0;
            we_reg        <= 1'b0;
            type_reg      <= '0;
            drop_reg      <= 1'b0;
            if_done_reg   <= 1'b0;
            if_valid_reg  <= 1'b0;
            dm_done_reg   <= 1'b0;
            if_inst_reg   <= '0;
            dm_rdata_reg  <= '0;
`ifdef ARB_TIMEOUT_EN
            to_cnt_reg    <= '0;
            bus_err_reg   <= 1'b0;
`endif
        end else begin
            state_reg     <= state_next;
            last_data_reg <= last_data_next;
            addr_reg      <= addr_next;
            wdata_reg     <= wdata_next;
            we_reg        <= we_next;
            type_reg      <= type_next;
            drop_reg      <= drop_next;
            if_done_reg   <= if_done_next;
            if_valid_reg  <= if_valid_next;
            dm_done_reg   <= dm_done_next;
            if_inst_reg   <= if_inst_next;
            dm_rdata_reg  <= dm_rdata_next;
`ifdef ARB_TIMEOUT_EN
            to_cnt_reg    <= to_cnt_next;
            bus_err_reg   <= bus_err_next;
`endif
        end
    end

    always_comb begin
        state_next     = state_reg;
        last_data_next = last_data_reg;
        addr_next      = addr_reg;
        wdata_next     = wdata_reg;
        we_next        = we_reg;
        type_next      = type_reg;
        drop_next      = drop_reg;
        if_done_next   = 1'b0;
        if_valid_next  = 1'b0;
        dm_done_next   = 1'b0;
        if_inst_next   = if_inst_reg;
        dm_rdata_next  = dm_rdata_reg;
`ifdef ARB_TIMEOUT_EN
        to_cnt_next    = to_cnt_reg;
        bus_err_next   = bus_err_reg;
`endif

        unique case (state_reg)
            IDLE: begin
                drop_next = 1'b0;
                // The done cycle is a recovery slot for both sides: grants are at least 3 cycles apart.
                if (!if_done_reg && !dm_done_reg) begin
                    if (dm_elig && (!if_elig || !last_data_reg)) begin
                        state_next = D_ACC;
                        addr_next  = dm_addr;
                        wdata_next = dm_wdata;
                        we_next    = dm_we;
                        type_next  = dm_type;
`ifdef ARB_TIMEOUT_EN
                        to_cnt_next = '0;
`endif
                    end else if (if_elig) begin
                        state_next = I_ACC;
                        addr_next  = if_addr;
                        wdata_next = '0;
                        we_next    = 1'b0;
                        type_next  = 3'b000;
                        drop_next  = if_flush;
`ifdef ARB_TIMEOUT_EN
                        to_cnt_next = '0;
`endif
                    end
                end
            end

            D_ACC: begin
                if (bus.bus_ready) begin
                    if (!we_reg) begin
                        dm_rdata_next = bus.bus_rdata;
                    end
                    dm_done_next   = 1'b1;
                    last_data_next = 1'b1;
                    state_next     = IDLE;
                end
`ifdef ARB_TIMEOUT_EN
                else if (to_cnt_reg == TO_W'(TIMEOUT)) begin
                    if (!we_reg) begin
                        dm_rdata_next = '0;
                    end
                    dm_done_next   = 1'b1;
                    last_data_next = 1'b1;
                    bus_err_next   = 1'b1;
                    state_next     = IDLE;
                end else begin
                    to_cnt_next = to_cnt_reg + 1'b1;
                end
`endif
            end

            I_ACC: begin
                // A redirect in the completing cycle still wins over the returned word.
                if (bus.bus_ready) begin
                    if (!flushed) begin
                        if_inst_next = bus.bus_rdata;
                    end
                    if_valid_next  = ~flushed;
                    if_done_next   = 1'b1;
                    last_data_next = 1'b0;
                    state_next     = IDLE;
                end
`ifdef ARB_TIMEOUT_EN
                else if (to_cnt_reg == TO_W'(TIMEOUT)) begin
                    if_inst_next   = NOP_INST;
                    if_valid_next  = 1'b1;
                    if_done_next   = 1'b1;
                    last_data_next = 1'b0;
                    bus_err_next   = 1'b1;
                    state_next     = IDLE;
                end else begin
                    to_cnt_next = to_cnt_reg + 1'b1;
                    drop_next   = flushed;
                end
`else
                else begin
                    drop_next = flushed;
                end
`endif
            end

            default: begin
                state_next = IDLE;
            end
        endcase
    end

    assign bus.bus_req   = (state_reg != IDLE);
    assign bus.bus_we    = (state_reg == D_ACC) & we_reg;
    assign bus.bus_addr  = addr_reg;
    assign bus.bus_wdata = wdata_reg;
    assign bus.bus_type  = type_reg;

    assign if_done  = if_done_reg;
    assign if_valid = if_valid_reg;
    assign if_inst  = if_inst_reg;
    assign dm_done  = dm_done_reg;
    assign dm_rdata = dm_rdata_reg;
    assign stall    = (if_req & ~if_done_reg) | (dm_req & ~dm_done_reg);

`ifdef ARB_TIMEOUT_EN
    assign bus_err = bus_err_reg;
`else
    assign bus_err = 1'b0;
`endif

endmodule
